cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of functional-unit requesters sharing the common data bus (CDB).
REQ-002 Parameter TAGW, default 4: reservation-station tag width.
REQ-003 Parameter DATAW, default 32: result data width.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 nRST  input  1  reset, asynchronous and active-low.
REQ-006 req  input  NREQ  per-requester CDB request; bit i high = unit i holds a finished result.
REQ-007 reqTag  input  NREQ*TAGW  packed tags; slice i = bits [i*TAGW +: TAGW].
REQ-008 reqData  input  NREQ*DATAW  packed results; slice i = bits [i*DATAW +: DATAW].
REQ-009 hold  input  1  CDB consumers cannot accept a broadcast this cycle.
REQ-010 ack  output  NREQ  one-hot-or-zero grant, combinational; unit i treats ack[i] as its result-accepted signal.
REQ-011 cdbValid  output  1  registered; broadcast valid.
REQ-012 cdbTag  output  TAGW  registered; broadcast tag.
REQ-013 cdbData  output  DATAW  registered; broadcast data.
REQ-014 cdbSrc  output  log2(NREQ)  registered; index of the unit that produced the broadcast.

Function
REQ-015 Round-robin pointer ptr (log2(NREQ) bits) SHALL hold the highest-priority requester index.
REQ-016 Winner SHALL be the first i with req[i]=1, searching ptr, ptr+1, ... modulo NREQ.
REQ-017 ack SHALL be zero when hold=1 or req=0; otherwise ack SHALL equal one-hot(winner).
REQ-018 ack SHALL depend only on req, hold and ptr, never on reqTag/reqData.
REQ-019 On a posedge with a grant, ptr SHALL become (winner+1) mod NREQ; with no grant, ptr SHALL be unchanged.
REQ-020 On a posedge with a grant, cdbValid<=1, cdbTag<=reqTag slice, cdbData<=reqData slice, cdbSrc<=winner (latency one cycle from ack to broadcast).
REQ-021 On a posedge without a grant, cdbValid<=0; cdbTag, cdbData, cdbSrc SHALL retain their values.
REQ-022 Back-to-back grants SHALL be allowed; a continuously requesting set of units SHALL be served at one broadcast per cycle.
REQ-023 A requester SHALL keep req, tag and data stable until it sees ack; the arbiter SHALL NOT buffer ungranted requests.
REQ-024 A requester deasserting req before ack SHALL lose its slot without side effect on ptr.
REQ-025 With all NREQ requesting continuously, each unit SHALL be granted exactly once every NREQ cycles (no starvation).
REQ-026 hold SHALL take effect in the same cycle: ack=0 and next cdbValid=0, regardless of req.
REQ-027 At most one ack bit SHALL be high in any cycle; cdbValid SHALL never be high for two cycles from one ack.

Reset
REQ-028 While nRST=0: ptr=0, cdbValid=0, cdbTag=0, cdbData=0, cdbSrc=0, immediately (asynchronous).
REQ-029 ack SHALL be forced to zero while nRST=0.
REQ-030 Reset asserted in the cycle after a grant SHALL cancel that broadcast (cdbValid=0); the granted result is lost and the surrounding pipeline is flushed by the same reset.
REQ-031 First grant after reset release SHALL use ptr=0.

Verification
REQ-032 Reset, then req=4'b0100, tag2=4'h5, data2=32'h0000_00AA -> ack=4'b0100 same cycle; next cycle cdbValid=1, cdbTag=5, cdbData=0xAA, cdbSrc=2; ptr=3.
REQ-033 req=4'b1111 held 8 cycles from ptr=0 -> ack sequence 0001,0010,0100,1000,0001,0010,0100,1000; cdbValid high 8 consecutive cycles.
REQ-034 ptr=3, req=4'b1001 -> ack=4'b1000; next ptr=0, then ack=4'b0001 (wrap-around).
REQ-035 req=4'b0011 with hold=1 for 3 cycles -> ack=0, cdbValid=0, ptr unchanged; hold drops -> ack=4'b0001 (ptr=0).
REQ-036 Grant to unit 1 (tag 0xC, data 0xDEAD_BEEF), nRST pulsed low mid-cycle before next edge -> cdbValid, cdbTag, cdbData, cdbSrc, ptr all 0 immediately; no broadcast of 0xC.
REQ-037 Single grant then req=0 -> cdbValid high exactly one cycle, cdbTag/cdbData/cdbSrc hold last values afterward.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: picks one finished functional
// unit per cycle, acknowledges it combinationally and broadcasts its result one cycle later.
module cdb_arbiter #(
    parameter int NREQ  = 4,
    parameter int TAGW  = 4,
    parameter int DATAW = 32,
    localparam int SRCW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  nRST,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*TAGW-1:0]  reqTag,
    input  logic [NREQ*DATAW-1:0] reqData,
    input  logic                  hold,
    output logic [NREQ-1:0]       ack,
    output logic                  cdbValid,
    output logic [TAGW-1:0]       cdbTag,
    output logic [DATAW-1:0]      cdbData,
    output logic [SRCW-1:0]       cdbSrc
);

    logic [SRCW-1:0]  ptr;
    logic [SRCW-1:0]  winner;
    logic [SRCW-1:0]  nextPtr;
    logic             anyReq;
    logic             grant;
    logic [TAGW-1:0]  selTag;
    logic [DATAW-1:0] selData;
    int               idx;

    // Scan from ptr upward with wrap; the first requester found wins.
    always_comb begin
        winner = '0;
        anyReq = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!anyReq && req[idx]) begin
                anyReq = 1'b1;
                winner = SRCW'(idx);
            end
        end
    end

    // Reset gates the grant so a unit never retires a result during reset.
    assign grant = nRST & ~hold & anyReq;

    always_comb begin
        ack = '0;
        if (grant) begin
            ack[winner] = 1'b1;
        end
    end

    assign nextPtr = (winner == SRCW'(NREQ - 1)) ? '0 : winner + SRCW'(1);
    assign selTag  = reqTag[winner*TAGW +: TAGW];
    assign selData = reqData[winner*DATAW +: DATAW];

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            ptr      <= '0;
            cdbValid <= 1'b0;
            cdbTag   <= '0;
            cdbData  <= '0;
            cdbSrc   <= '0;
        end else if (grant) begin
            ptr      <= nextPtr;
            cdbValid <= 1'b1;
            cdbTag   <= selTag;
            cdbData  <= selData;
            cdbSrc   <= winner;
        end else begin
            cdbValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: stimulus pushes expected broadcasts into a
// queue, a negedge monitor pops and compares whenever cdbValid is high.
module tb_cdb_arbiter;

    localparam int NREQ  = 4;
    localparam int TAGW  = 4;
    localparam int DATAW = 32;
    localparam int SRCW  = 2;

    typedef struct packed {
        logic [TAGW-1:0]  tag;
        logic [DATAW-1:0] data;
        logic [SRCW-1:0]  src;
    } bcast_t;

    logic                  clk;
    logic                  nRST;
    logic [NREQ-1:0]       req;
    logic [NREQ*TAGW-1:0]  reqTag;
    logic [NREQ*DATAW-1:0] reqData;
    logic                  hold;
    logic [NREQ-1:0]       ack;
    logic                  cdbValid;
    logic [TAGW-1:0]       cdbTag;
    logic [DATAW-1:0]      cdbData;
    logic [SRCW-1:0]       cdbSrc;

    logic [TAGW-1:0]  tagArr  [NREQ];
    logic [DATAW-1:0] dataArr [NREQ];

    bcast_t expQ [$];
    int checks = 0;
    int errors = 0;

    cdb_arbiter #(.NREQ(NREQ), .TAGW(TAGW), .DATAW(DATAW)) dut (
        .clk      (clk),
        .nRST     (nRST),
        .req      (req),
        .reqTag   (reqTag),
        .reqData  (reqData),
        .hold     (hold),
        .ack      (ack),
        .cdbValid (cdbValid),
        .cdbTag   (cdbTag),
        .cdbData  (cdbData),
        .cdbSrc   (cdbSrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            reqTag[i*TAGW +: TAGW]    = tagArr[i];
            reqData[i*DATAW +: DATAW] = dataArr[i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One arbitration cycle: drive at negedge, check ptr and the combinational ack.
    task automatic cycle(input logic [NREQ-1:0] r, input logic h,
                         input logic [NREQ-1:0] expAck, input int expPtr,
                         input logic doPush);
        bcast_t b;
        @(negedge clk);
        req  = r;
        hold = h;
        #1;
        check("ptr", 64'(dut.ptr), 64'(expPtr));
        check("ack", 64'(ack), 64'(expAck));
        if (doPush && expAck != '0) begin
            b.src = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (expAck[i]) b.src = SRCW'(i);
            end
            b.tag  = tagArr[b.src];
            b.data = dataArr[b.src];
            expQ.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        bcast_t e;
        if (cdbValid === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL bcast_unexpected: got tag %0h data %0h src %0d, expected none",
                         cdbTag, cdbData, cdbSrc);
            end else begin
                e = expQ.pop_front();
                if (cdbTag !== e.tag || cdbData !== e.data || cdbSrc !== e.src) begin
                    errors++;
                    $display("FAIL bcast: got tag %0h data %0h src %0d expected tag %0h data %0h src %0d",
                             cdbTag, cdbData, cdbSrc, e.tag, e.data, e.src);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            tagArr[i]  = TAGW'(i + 8);
            dataArr[i] = 32'h1000_0000 + 32'(i);
        end
        nRST = 1'b0;
        hold = 1'b0;
        req  = 4'b1111;
        #3;
        check("rst_valid", 64'(cdbValid), 64'd0);
        check("rst_tag",   64'(cdbTag),   64'd0);
        check("rst_data",  64'(cdbData),  64'd0);
        check("rst_src",   64'(cdbSrc),   64'd0);
        check("rst_ptr",   64'(dut.ptr),  64'd0);
        check("rst_ack",   64'(ack),      64'd0);
        req = '0;
        @(negedge clk);
        nRST = 1'b1;

        // single grant to unit 2, then idle: one broadcast, fields retained
        tagArr[2]  = 4'h5;
        dataArr[2] = 32'h0000_00AA;
        cycle(4'b0100, 1'b0, 4'b0100, 0, 1'b1);
        cycle(4'b0000, 1'b0, 4'b0000, 3, 1'b1);
        cycle(4'b0000, 1'b0, 4'b0000, 3, 1'b1);
        check("idle_valid", 64'(cdbValid), 64'd0);
        check("idle_tag",   64'(cdbTag),   64'h5);
        check("idle_data",  64'(cdbData),  64'hAA);
        check("idle_src",   64'(cdbSrc),   64'd2);

        // wrap-around from ptr=3
        cycle(4'b1001, 1'b0, 4'b1000, 3, 1'b1);
        cycle(4'b1001, 1'b0, 4'b0001, 0, 1'b1);
        cycle(4'b0000, 1'b0, 4'b0000, 1, 1'b1);

        // bring ptr to 0, then hold for three cycles
        cycle(4'b1000, 1'b0, 4'b1000, 1, 1'b1);
        cycle(4'b0011, 1'b1, 4'b0000, 0, 1'b1);
        cycle(4'b0011, 1'b1, 4'b0000, 0, 1'b1);
        check("hold_valid1", 64'(cdbValid), 64'd0);
        cycle(4'b0011, 1'b1, 4'b0000, 0, 1'b1);
        check("hold_valid2", 64'(cdbValid), 64'd0);
        cycle(4'b0011, 1'b0, 4'b0001, 0, 1'b1);
        check("hold_valid3", 64'(cdbValid), 64'd0);
        cycle(4'b0010, 1'b0, 4'b0010, 1, 1'b1);
        cycle(4'b0000, 1'b0, 4'b0000, 2, 1'b1);

        // ptr back to 0, then all four requesting for eight cycles
        cycle(4'b1000, 1'b0, 4'b1000, 2, 1'b1);
        for (int n = 0; n < 8; n++) begin
            cycle(4'b1111, 1'b0, 4'(1 << (n % 4)), n % 4, 1'b1);
        end
        cycle(4'b0000, 1'b0, 4'b0000, 0, 1'b1);
        check("rr_last_valid", 64'(cdbValid), 64'd1);

        // grant to unit 1 cancelled by a reset pulse before the broadcast is seen
        tagArr[1]  = 4'hC;
        dataArr[1] = 32'hDEAD_BEEF;
        cycle(4'b0010, 1'b0, 4'b0010, 0, 1'b0);
        @(posedge clk);
        #2;
        nRST = 1'b0;
        #1;
        check("mid_rst_valid", 64'(cdbValid), 64'd0);
        check("mid_rst_tag",   64'(cdbTag),   64'd0);
        check("mid_rst_data",  64'(cdbData),  64'd0);
        check("mid_rst_src",   64'(cdbSrc),   64'd0);
        check("mid_rst_ptr",   64'(dut.ptr),  64'd0);
        check("mid_rst_ack",   64'(ack),      64'd0);
        #1;
        nRST = 1'b1;

        // first grant after reset starts from ptr=0
        cycle(4'b0110, 1'b0, 4'b0010, 0, 1'b1);
        cycle(4'b0000, 1'b0, 4'b0000, 2, 1'b1);
        cycle(4'b0000, 1'b0, 4'b0000, 2, 1'b1);
        check("queue_drained", 64'(expQ.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
